cfg_bitstream_loader: RTL and testbench
=======================================

# cfg_bitstream_loader

Byte-stream configuration sequencer that drives the eFPGA frame-load port. Accepts a framed bitstream over a valid/ready byte interface and checks its header. For each frame it serialises 192 frame-data bits onto `fd_shift`/`fd_data`, then issues the row-strobe and counter-increment pulses that write the frame and advance the frame address. It sits directly upstream of the frame data register and frame-strobe counter in the user project wrapper, replacing pin-driven configuration.

## Interface
- `FRAME_BITS`, 192: bits per frame (NumberOfRows*FrameBitsPerRow); must be a multiple of 8.
- `MAX_FRAMES`, 288: largest legal frame count (NumberOfCols*MaxFramesPerCol).
- `SYNC_WORD`, 16'hA55A: header sync, high byte first.
- `config_clk` in 1: sole clock; all state changes on its rising edge.
- `config_rst_n` in 1: reset, synchronous, active-low.
- `s_data` in 8: bitstream byte.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: loader accepts byte this cycle.
- `abort` in 1: synchronous return to IDLE; overrides everything except reset.
- `fd_shift` out 1: shift enable to frame data register.
- `fd_data` out 1: serial frame bit.
- `rs_reset` out 1: clear frame-strobe counter.
- `rs_incr` out 1: increment frame-strobe counter.
- `rs_strobe` out 1: write current frame.
- `busy` out 1: state is not IDLE/DONE/ERROR.
- `done` out 1: sticky; load completed with good checksum.
- `error` out 1: sticky; bad length or checksum.
- `frames_loaded` out 9: frames strobed since last sync.

## Operation
- Stream format: SYNC hi, SYNC lo, N hi, N lo (big-endian 16-bit frame count), N×(FRAME_BITS/8) data bytes, 1 checksum byte (XOR of all data bytes).
- Handshake: a byte transfers when `s_valid & s_ready`. `s_ready` is a combinational state decode: 1 in IDLE, SYNC1, LEN_HI, LEN_LO, LOAD, CHECK, DONE, ERROR; 0 otherwise.
- Each frame byte is shifted out LSB first. The first bit of the frame ends at frame register bit 0.
- States and transitions:
  - IDLE: byte == SYNC hi → SYNC1; any other byte is consumed, with no state change.
  - SYNC1: byte == SYNC lo → LEN_HI. Byte == SYNC hi → stay. Any other byte → IDLE.
  - LEN_HI → LEN_LO, latching N[15:8].
  - LEN_LO: latches N[7:0]. N==0 or N>MAX_FRAMES → ERROR; otherwise → CLR.
  - CLR (1 cycle): `rs_reset`=1, checksum:=0, `frames_loaded`:=0 → LOAD.
  - LOAD: an accepted byte is captured into the shift byte, the checksum is XORed, and the state goes → SHIFT.
  - SHIFT (8 cycles): `fd_shift`=1 and `fd_data`=byte[k] for k=0..7. After bit 7: if the frame's last byte was sent → STROBE, else → LOAD.
  - STROBE (1 cycle): `rs_strobe`=1 → INCR.
  - INCR (1 cycle): `rs_incr`=1 and `frames_loaded`+1. If `frames_loaded`+1 == N → CHECK, else → LOAD.
  - CHECK: accepted byte == checksum → DONE (`done`:=1); otherwise → ERROR (`error`:=1).
  - DONE/ERROR: behave as IDLE for sync hunting. The first SYNC hi byte clears `done`/`error` → SYNC1.
- `abort` in any state → IDLE next cycle. A partially shifted frame is not strobed. `done`, `error` and `frames_loaded` are held.
- `rs_*` and `fd_*` are registered. At most one of `fd_shift`, `rs_reset`, `rs_strobe`, `rs_incr` is high in any cycle.
- Ordering rule: strobe precedes incr, so frame i is written while the counter equals i.

## Timing
- Reset (`config_rst_n`=0 at an edge): state IDLE; all `fd_*`/`rs_*`=0; `busy`/`done`/`error`=0; `frames_loaded`=0; byte/bit/frame counters=0; `s_ready`=1 after that edge.
- Reset mid-SHIFT: `fd_shift` is 0 from the next cycle; no strobe is issued.
- With `s_valid` held high, each data byte costs 9 cycles (1 LOAD + 8 SHIFT).
- A frame costs 24×9+2 = 218 cycles.
- `rs_strobe` rises the cycle after the last `fd_shift` cycle of a frame.
- `rs_reset` is high for exactly 1 cycle, 1 cycle after the N lo byte is accepted.
- `s_valid` gaps stall only in LOAD/CHECK/header states; SHIFT/STROBE/INCR never wait on input.
- `done`/`error` assert the cycle after the checksum byte is accepted.

## Test plan
- 1-frame load with data bytes 0x01,0x00…0x00 and checksum 0x01:
  - `rs_reset` pulses once.
  - 192 `fd_shift` cycles occur, with `fd_data`=1 only on the first.
  - One `rs_strobe` is followed by one `rs_incr`.
  - `frames_loaded`=1 and `done`=1.
- N=3 with continuous valid: three strobe/incr pairs occur 218 cycles apart, and `frames_loaded`=3.
- Stream 0x00,0xA5,0xA5,0x5A,N=1…:
  - Garbage bytes are consumed.
  - Lock occurs on the second 0xA5, and the load completes normally.
- N=0 → `error`=1, with no `rs_reset` pulse. Repeat with N=289 → `error`=1.
- Wrong checksum on a 2-frame load: 2 frames are strobed, then `error`=1 and `done`=0.
- Reset and abort, each applied separately mid-SHIFT of frame 2:
  - Abort: no further `fd_shift`/`rs_strobe`; `frames_loaded` stays 1.
  - Reset: `frames_loaded`=0.
  - In both cases, a subsequent full load completes with `done`=1.

Source files
------------

// File: rtl/cfg_bitstream_loader_if.sv
// cfg_bitstream_loader_if: valid/ready byte stream carrying the configuration bitstream
interface cfg_bitstream_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  modport master (output s_data, s_valid, input s_ready);
  modport slave (input s_data, s_valid, output s_ready);
endinterface

// File: rtl/cfg_bitstream_loader.sv
// cfg_bitstream_loader: checks a framed byte bitstream and serialises each frame into the
// frame data register, then strobes the row and advances the frame-strobe counter
module cfg_bitstream_loader #(
  parameter int          FRAME_BITS = 192,
  parameter int          MAX_FRAMES = 288,
  parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
  input  logic                         config_clk,
  input  logic                         config_rst_n,
  cfg_bitstream_loader_if.slave        s,
  input  logic                         abort,
  output logic                         fd_shift,
  output logic                         fd_data,
  output logic                         rs_reset,
  output logic                         rs_incr,
  output logic                         rs_strobe,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [8:0]                   frames_loaded
);
  localparam int BYTES = FRAME_BITS / 8;
  localparam int BW = $clog2(BYTES + 1);
  typedef enum logic [3:0] {
    IDLE, SYNC1, LEN_HI, LEN_LO, CLR, LOAD, SHIFT, STROBE, INCR, CHECK, DONE, ERROR
  } state_t;
  state_t state_q, state_d;
  logic [7:0] sr_q, sr_d, csum_q, csum_d;
  logic [15:0] n_q, n_d, n_new, fl_next;
  logic [BW-1:0] byte_q, byte_d;
  logic [2:0] bit_q, bit_d;
  logic [8:0] fl_q, fl_d;
  logic done_q, done_d, err_q, err_d;
  logic fd_shift_q, fd_data_q, rs_reset_q, rs_incr_q, rs_strobe_q;
  logic acc, sync_hi, sync_lo, len_bad;
  assign s.s_ready = !(state_q inside {CLR, SHIFT, STROBE, INCR});
  assign busy = !(state_q inside {IDLE, DONE, ERROR});
  assign acc = s.s_valid & s.s_ready;
  assign sync_hi = s.s_data == SYNC_WORD[15:8];
  assign sync_lo = s.s_data == SYNC_WORD[7:0];
  assign n_new = {n_q[15:8], s.s_data};
  assign len_bad = (n_new == 16'd0) || (n_new > 16'(MAX_FRAMES));
  assign fl_next = {7'd0, fl_q} + 16'd1;
  assign fd_shift = fd_shift_q;
  assign fd_data = fd_data_q;
  assign rs_reset = rs_reset_q;
  assign rs_incr = rs_incr_q;
  assign rs_strobe = rs_strobe_q;
  assign done = done_q;
  assign error = err_q;
  assign frames_loaded = fl_q;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    csum_d = csum_q;
    n_d = n_q;
    byte_d = byte_q;
    bit_d = bit_q;
    fl_d = fl_q;
    done_d = done_q;
    err_d = err_q;
    case (state_q)
      IDLE, DONE, ERROR: if (acc && sync_hi) begin
        state_d = SYNC1;
        if (state_q != IDLE) begin
          done_d = 1'b0;
          err_d = 1'b0;
        end
      end
      SYNC1: if (acc) state_d = sync_lo ? LEN_HI : sync_hi ? SYNC1 : IDLE;
      LEN_HI: if (acc) begin
        n_d[15:8] = s.s_data;
        state_d = LEN_LO;
      end
      LEN_LO: if (acc) begin
        n_d[7:0] = s.s_data;
        state_d = len_bad ? ERROR : CLR;
        err_d = err_q | len_bad;
      end
      CLR: begin
        csum_d = '0;
        fl_d = '0;
        byte_d = '0;
        state_d = LOAD;
      end
      LOAD: if (acc) begin
        sr_d = s.s_data;
        csum_d = csum_q ^ s.s_data;
        byte_d = (byte_q == BW'(BYTES - 1)) ? '0 : byte_q + 1'b1;
        bit_d = '0;
        state_d = SHIFT;
      end
      // byte counter wraps to 0 on the frame's last byte, which selects the strobe
      SHIFT: begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = (byte_q == '0) ? STROBE : LOAD;
      end
      STROBE: state_d = INCR;
      INCR: begin
        fl_d = fl_q + 9'd1;
        state_d = (fl_next == n_q) ? CHECK : LOAD;
      end
      CHECK: if (acc) begin
        state_d = (s.s_data == csum_q) ? DONE : ERROR;
        done_d = s.s_data == csum_q;
        err_d = s.s_data != csum_q;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      fl_d = fl_q;
      done_d = done_q;
      err_d = err_q;
    end
  end
  // strobe/shift outputs are registered decodes of the next state
  always_ff @(posedge config_clk) begin
    if (!config_rst_n) begin
      state_q <= IDLE;
      sr_q <= '0;
      csum_q <= '0;
      n_q <= '0;
      byte_q <= '0;
      bit_q <= '0;
      fl_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      fd_shift_q <= 1'b0;
      fd_data_q <= 1'b0;
      rs_reset_q <= 1'b0;
      rs_incr_q <= 1'b0;
      rs_strobe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      csum_q <= csum_d;
      n_q <= n_d;
      byte_q <= byte_d;
      bit_q <= bit_d;
      fl_q <= fl_d;
      done_q <= done_d;
      err_q <= err_d;
      fd_shift_q <= state_d == SHIFT;
      fd_data_q <= (state_d == SHIFT) && (state_q == LOAD ? s.s_data[0] : sr_q[bit_d]);
      rs_reset_q <= state_d == CLR;
      rs_incr_q <= state_d == INCR;
      rs_strobe_q <= state_d == STROBE;
    end
  end
endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// tb_cfg_bitstream_loader: randomized bitstream loads checked against a frame-level model
module tb_cfg_bitstream_loader;
  logic config_clk = 1'b0;
  logic config_rst_n = 1'b0;
  logic abort = 1'b0;
  logic fd_shift, fd_data, rs_reset, rs_incr, rs_strobe, busy, done, error;
  logic [8:0] frames_loaded;
  cfg_bitstream_loader_if bus ();
  cfg_bitstream_loader dut (
    .config_clk(config_clk), .config_rst_n(config_rst_n), .s(bus), .abort(abort),
    .fd_shift(fd_shift), .fd_data(fd_data), .rs_reset(rs_reset), .rs_incr(rs_incr),
    .rs_strobe(rs_strobe), .busy(busy), .done(done), .error(error),
    .frames_loaded(frames_loaded)
  );
  always #5 config_clk = ~config_clk;
  int n_cmp = 0, n_err = 0, cyc = 0;
  int nshift = 0, nincr = 0, nreset = 0, seq_err = 0, onehot_err = 0, exp_fl = 0;
  logic prev_shift = 1'b0, prev_strobe = 1'b0;
  logic bits[$];
  int strobe_cyc[$];
  int strobe_sh[$];
  always @(posedge config_clk) cyc <= cyc + 1;
  always @(negedge config_clk) begin
    if (fd_shift) begin
      bits.push_back(fd_data);
      nshift++;
    end
    if (rs_strobe) begin
      strobe_cyc.push_back(cyc);
      strobe_sh.push_back(nshift);
      if (!prev_shift) seq_err++;
    end
    if (rs_incr) begin
      nincr++;
      if (!prev_strobe) seq_err++;
    end
    if (rs_reset) nreset++;
    if (int'(fd_shift) + int'(rs_reset) + int'(rs_strobe) + int'(rs_incr) > 1) onehot_err++;
    prev_shift = fd_shift;
    prev_strobe = rs_strobe;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int t = 0;
    bus.s_data = b;
    bus.s_valid = 1'b1;
    while (1) begin
      @(negedge config_clk);
      if (bus.s_ready) break;
      t++;
      if (t > 300) begin
        n_cmp++;
        n_err++;
        $error("FAIL send_timeout: observed no s_ready in 300 cycles expected ready");
        return;
      end
    end
    @(posedge config_clk);
    #1;
  endtask
  task automatic hdr(input logic [15:0] n);
    send(8'hA5);
    send(8'h5A);
    send(n[15:8]);
    send(n[7:0]);
  endtask
  task automatic load(input int n, input int mode, input bit bad, input bit gaps);
    int b0 = bits.size(), s0 = strobe_cyc.size(), r0 = nreset, i0 = nincr, sh0 = nshift;
    bit legal = (n >= 1) && (n <= 288);
    logic eb[$];
    logic [7:0] cs = 8'h00, d;
    int mm;
    hdr(16'(n));
    chk("rs_reset_after_len", rs_reset, legal);
    chk("busy_after_len", busy, legal);
    if (legal) begin
      for (int i = 0; i < n * 24; i++) begin
        d = (mode == 1) ? ((i == 0) ? 8'h01 : 8'h00) : 8'($urandom);
        cs ^= d;
        for (int k = 0; k < 8; k++) eb.push_back(d[k]);
        if (gaps && $urandom_range(0, 3) == 0) begin
          bus.s_valid = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge config_clk);
          #1;
        end
        send(d);
      end
      send(bad ? cs ^ 8'($urandom_range(1, 255)) : cs);
      exp_fl = n;
    end
    bus.s_valid = 1'b0;
    chk("done", done, legal && !bad);
    chk("error", error, !legal || bad);
    chk("frames_loaded", frames_loaded, exp_fl);
    chk("busy_end", busy, 0);
    chk("rs_reset_count", nreset - r0, legal);
    chk("bit_count", bits.size() - b0, eb.size());
    mm = 0;
    for (int i = 0; i < eb.size() && b0 + i < bits.size(); i++) if (bits[b0 + i] !== eb[i]) mm++;
    chk("bit_values", mm, 0);
    chk("strobe_count", strobe_cyc.size() - s0, legal ? n : 0);
    chk("incr_count", nincr - i0, legal ? n : 0);
    mm = 0;
    for (int i = s0; i < strobe_cyc.size(); i++) begin
      if (strobe_sh[i] - sh0 != (i - s0 + 1) * 192) mm++;
      if (!gaps && i > s0 && strobe_cyc[i] - strobe_cyc[i - 1] != 218) mm++;
    end
    chk("strobe_timing", mm, 0);
    chk("sequence_errors", seq_err, 0);
    chk("onehot_errors", onehot_err, 0);
  endtask
  task automatic partial();
    hdr(16'd3);
    for (int i = 0; i < 27; i++) send(8'($urandom));
    bus.s_valid = 1'b0;
    chk("fl_before_interrupt", frames_loaded, 1);
    chk("shifting_before_interrupt", fd_shift, 1);
    @(negedge config_clk);
    @(negedge config_clk);
  endtask
  task automatic quiet(input string tag);
    int ns = nshift, ss = strobe_cyc.size();
    chk({tag, "_fd_shift"}, fd_shift, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 1);
    chk({tag, "_frames_loaded"}, frames_loaded, exp_fl);
    repeat (20) @(negedge config_clk);
    chk({tag, "_no_more_shift"}, nshift - ns, 0);
    chk({tag, "_no_more_strobe"}, strobe_cyc.size() - ss, 0);
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [7:0] g;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    repeat (2) @(posedge config_clk);
    #1;
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_frames_loaded", frames_loaded, 0);
    chk("rst_outputs", {fd_shift, fd_data, rs_reset, rs_incr, rs_strobe}, 0);
    config_rst_n = 1'b1;
    load(1, 1, 1'b0, 1'b0);
    load(3, 0, 1'b0, 1'b0);
    send(8'h00);
    send(8'hA5);
    load(1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      g = 8'($urandom);
      send(g == 8'hA5 ? 8'h00 : g);
    end
    load(2, 0, 1'b0, 1'b1);
    load(0, 0, 1'b0, 1'b0);
    load(289, 0, 1'b0, 1'b0);
    load(2, 0, 1'b1, 1'b0);
    partial();
    abort = 1'b1;
    @(posedge config_clk);
    #1;
    abort = 1'b0;
    exp_fl = 1;
    quiet("abort");
    load(1, 0, 1'b0, 1'b0);
    partial();
    config_rst_n = 1'b0;
    @(posedge config_clk);
    #1;
    config_rst_n = 1'b1;
    exp_fl = 0;
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    quiet("reset");
    load(2, 0, 1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
